cla_accum_16bit: RTL and testbench

- Streaming accumulator stage wrapped around one cla_16bit instance (C0 tied 0).
- Accepts a stream of 16-bit operands over a valid/ready handshake and adds each into a registered running sum.
- Tracks unsigned carry and signed overflow as sticky flags, and counts accepted beats.
- Presents the final sum, flags and count to the downstream consumer when the stream's last beat is accepted.

---
 rtl/cla_accum_16bit.sv | 163 ++++++++++++++++
 tb/tb_cla_accum_16bit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_accum_16bit.sv
// rtl/cla_accum_16bit.sv - streaming 16-bit accumulator built around a carry-lookahead adder

// cla_4bit - 4-bit carry-lookahead slice exporting group generate/propagate
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       g_grp,
  output logic       p_grp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Flat lookahead equations for the internal carries of one slice
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    sum  = p ^ c;
    g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    p_grp = &p;
  end

endmodule

// cla_16bit - two-level carry-lookahead adder made of four 4-bit slices
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [3:0] gg;
  logic [3:0] pg;
  logic [4:0] cg;

  // Second-level lookahead produces every slice carry-in in parallel
  always_comb begin
    cg[0] = c_in;
    cg[1] = gg[0] | (pg[0] & c_in);
    cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_in);
    cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & c_in);
    cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & c_in);
    c_out = cg[4];
  end

  for (genvar i = 0; i < 4; i++) begin : g_slice
    cla_4bit u_slice (
      .a     (a[4*i +: 4]),
      .b     (b[4*i +: 4]),
      .c_in  (cg[i]),
      .sum   (sum[4*i +: 4]),
      .g_grp (gg[i]),
      .p_grp (pg[i])
    );
  end

endmodule

// cla_accum_16bit - accumulates a valid/ready operand stream with sticky flags and beat count
module cla_accum_16bit #(
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic [15:0]      acc,
  output logic             carry_out,
  output logic             ovf,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0] sum;
  logic        c16;
  logic        accept;
  logic        beat_ovf;
  logic [15:0] acc_nxt;

  cla_16bit u_cla (
    .a     (acc),
    .b     (in_data),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c16)
  );

  // Beat acceptance, overflow detection and the saturating/wrapping result select
  always_comb begin
    accept   = (state == ACCUM) && in_valid && !start;
    beat_ovf = (acc[15] == in_data[15]) && (sum[15] != acc[15]);
    acc_nxt  = (SATURATE && c16) ? 16'hFFFF : sum;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start always (re)enters ACCUM, the last accepted beat ends the stream
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (!start && accept && in_last) state_nxt = DONE;
      DONE:    if (start) state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
  end

  // Running sum, sticky flags and saturating beat counter
  always_ff @(posedge clk) begin
    if (rst || start) begin
      acc       <= '0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
      count     <= '0;
    end else if (accept) begin
      acc       <= acc_nxt;
      carry_out <= carry_out | c16;
      ovf       <= ovf | beat_ovf;
      if (count != {CNT_W{1'b1}}) begin
        count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Status outputs decode from state only
  always_comb begin
    in_ready = (state == ACCUM);
    busy     = (state == ACCUM);
    done     = (state == DONE);
  end

endmodule

// File: tb/tb_cla_accum_16bit.sv
// tb/tb_cla_accum_16bit.sv - scoreboard bench for cla_accum_16bit (wrap, saturate and narrow-count variants)
module tb_cla_accum_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_last = 1'b0;

  logic [15:0] acc0, acc1, acc2;
  logic        rdy0, rdy1, rdy2;
  logic        c0, c1, c2;
  logic        o0, o1, o2;
  logic [7:0]  n0, n1;
  logic [1:0]  n2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          inst;
    logic [15:0] acc;
    logic        c;
    logic        o;
    int          n;
  } exp_t;

  exp_t exp_q[$];

  logic [15:0] m_acc[3];
  logic        m_c[3];
  logic        m_o[3];
  int          m_cnt[3];
  int          m_sat[3]  = '{0, 1, 0};
  int          m_cmax[3] = '{255, 255, 3};

  always #5 clk = ~clk;

  cla_accum_16bit #(.CNT_W(8), .SATURATE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .acc(acc0), .carry_out(c0), .ovf(o0),
    .count(n0), .busy(busy0), .done(done0)
  );

  cla_accum_16bit #(.CNT_W(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last), .acc(acc1), .carry_out(c1), .ovf(o1),
    .count(n1), .busy(busy1), .done(done1)
  );

  cla_accum_16bit #(.CNT_W(2), .SATURATE(1'b0)) u_cnt (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .in_last(in_last), .acc(acc2), .carry_out(c2), .ovf(o2),
    .count(n2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 16'h0;
      m_c[k]   = 1'b0;
      m_o[k]   = 1'b0;
      m_cnt[k] = 0;
    end
  endtask

  task automatic model_add(input logic [15:0] d);
    logic [16:0] s;
    for (int k = 0; k < 3; k++) begin
      s = {1'b0, m_acc[k]} + {1'b0, d};
      m_o[k]   = m_o[k] | ((m_acc[k][15] == d[15]) && (s[15] != m_acc[k][15]));
      m_c[k]   = m_c[k] | s[16];
      m_acc[k] = (m_sat[k] != 0 && s[16]) ? 16'hFFFF : s[15:0];
      if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
    end
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1;
    in_valid = v;
    in_data = 16'h0001;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    model_clear();
  endtask

  task automatic do_start(input logic v, input logic [15:0] d);
    start = 1'b1;
    in_valid = v;
    in_data = d;
    in_last = 1'b0;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    model_clear();
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    exp_t e;
    check("in_ready_before_beat", {31'b0, rdy0}, 32'd1);
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    model_add(d);
    if (last) begin
      for (int k = 0; k < 3; k++) begin
        e.inst = k; e.acc = m_acc[k]; e.c = m_c[k]; e.o = m_o[k]; e.n = m_cnt[k];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic collect;
    exp_t e;
    int waited = 0;
    while (!done0 && waited < 20) begin
      tick();
      waited++;
    end
    check("done_seen", {31'b0, done0}, 32'd1);
    check("in_ready_in_done", {31'b0, rdy0}, 32'd0);
    check("busy_in_done", {31'b0, busy0}, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.inst)
        0: begin
          check("acc_wrap", {16'b0, acc0}, {16'b0, e.acc});
          check("carry_wrap", {31'b0, c0}, {31'b0, e.c});
          check("ovf_wrap", {31'b0, o0}, {31'b0, e.o});
          check("count_wrap", {24'b0, n0}, e.n);
        end
        1: begin
          check("acc_sat", {16'b0, acc1}, {16'b0, e.acc});
          check("carry_sat", {31'b0, c1}, {31'b0, e.c});
          check("done_sat", {31'b0, done1}, 32'd1);
        end
        default: begin
          check("acc_cnt2", {16'b0, acc2}, {16'b0, e.acc});
          check("count_cnt2", {30'b0, n2}, e.n);
          check("done_cnt2", {31'b0, done2}, 32'd1);
        end
      endcase
    end
  endtask

  initial begin
    model_clear();
    tick();
    do_reset(1'b0);
    check("rst_acc", {16'b0, acc0}, 32'd0);
    check("rst_count", {24'b0, n0}, 32'd0);
    check("rst_flags", {30'b0, c0, o0}, 32'd0);
    check("rst_busy_done_ready", {29'b0, busy0, done0, rdy0}, 32'd0);
    tick();
    check("idle_ready", {31'b0, rdy0}, 32'd0);

    do_start(1'b0, 16'h0);
    check("start_busy", {31'b0, busy0}, 32'd1);
    beat(16'h1234, 1'b0);
    beat(16'h4321, 1'b1);
    collect();
    check("acc_5555_const", {16'b0, acc0}, 32'h5555);

    do_start(1'b0, 16'h0);
    beat(16'hFFFF, 1'b0);
    beat(16'h0001, 1'b1);
    collect();
    check("sat_clamp_const", {16'b0, acc1}, 32'hFFFF);

    do_start(1'b0, 16'h0);
    beat(16'd30000, 1'b0);
    beat(16'd30000, 1'b1);
    collect();
    check("ovf_const", {31'b0, o0}, 32'd1);

    repeat (3) tick();
    check("done_holds", {31'b0, done0}, 32'd1);
    do_start(1'b0, 16'h0);
    beat(16'd10000, 1'b0);
    beat(16'd20000, 1'b1);
    collect();

    do_start(1'b0, 16'h0);
    beat(16'd12345, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {16'b0, acc0}, {16'b0, m_acc[0]});
      tick();
    end
    beat(16'd5432, 1'b1);
    collect();

    do_start(1'b0, 16'h0);
    beat(16'hAAAA, 1'b0);
    do_start(1'b1, 16'h5555);
    check("restart_acc", {16'b0, acc0}, 32'd0);
    check("restart_count", {24'b0, n0}, 32'd0);
    check("restart_busy", {31'b0, busy0}, 32'd1);
    beat(16'h5555, 1'b1);
    collect();

    do_start(1'b0, 16'h0);
    beat(16'h0001, 1'b0);
    beat(16'h0001, 1'b0);
    do_reset(1'b1);
    check("midrst_acc", {16'b0, acc0}, 32'd0);
    check("midrst_count", {24'b0, n0}, 32'd0);
    check("midrst_busy_ready", {30'b0, busy0, rdy0}, 32'd0);

    do_start(1'b0, 16'h0);
    for (int i = 0; i < 5; i++) beat(16'h0001, (i == 4));
    collect();
    check("cnt_sat_const", {30'b0, n2}, 32'd3);

    do_start(1'b0, 16'h0);
    for (int i = 0; i < 6; i++) beat(16'($urandom), (i == 5));
    collect();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
